// File: rtl/vs10xx_stream_ctrl.sv
// rtl/vs10xx_stream_ctrl.sv - VS10xx decoder controller: reset, SCI init, DREQ-gated SDI streaming
module vs10xx_stream_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 17,
  parameter int TRACK_W    = 3,
  parameter int BOOT_CYC   = 2000,
  parameter int HRESET_CYC = 2000,
  parameter int SRESET_CYC = 10000,
  parameter int GAP_CYC    = 2000,
  parameter int SCK_DIV    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play,
  input  logic [TRACK_W-1:0] track,
  input  logic [15:0]        volume,
  input  logic [15:0]        bass,
  input  logic               DREQ,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               mem_valid,
  input  logic               mem_last,
  output logic               XCS,
  output logic               XDCS,
  output logic               SCK,
  output logic               SI,
  output logic               XRESET,
  output logic               busy,
  output logic               track_done
);

  // Shift register is wide enough for either a 32-bit SCI frame or one SDI word.
  localparam int SH_W  = (DATA_W > 32) ? DATA_W : 32;
  localparam int C1    = (BOOT_CYC > HRESET_CYC) ? BOOT_CYC : HRESET_CYC;
  localparam int C2    = (SRESET_CYC > GAP_CYC) ? SRESET_CYC : GAP_CYC;
  localparam int CMAX  = (C1 > C2) ? C1 : C2;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int DV_W  = $clog2(SCK_DIV) + 1;
  localparam logic [DV_W-1:0] DV_LAST = DV_W'(SCK_DIV - 1);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_HRST  = 3'd1;
  localparam logic [2:0] S_SWAIT = 3'd2;
  localparam logic [2:0] S_SCI   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_FETCH = 3'd5;
  localparam logic [2:0] S_SDI   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] F_MODE = 2'd0;
  localparam logic [1:0] F_BASS = 2'd1;
  localparam logic [1:0] F_CLKF = 2'd2;
  localparam logic [1:0] F_VOL  = 2'd3;

  function automatic logic [31:0] frame_word(input logic [1:0] sel,
                                             input logic [15:0] b,
                                             input logic [15:0] v);
    logic [31:0] f;
    case (sel)
      F_MODE:  f = {8'h02, 8'h00, 16'h0804};
      F_BASS:  f = {8'h02, 8'h02, b};
      F_CLKF:  f = {8'h02, 8'h03, 16'h7000};
      default: f = {8'h02, 8'h0B, v};
    endcase
    return f;
  endfunction

  logic              rst_meta_q, rst_sync_q;
  logic [TRACK_W-1:0] track_q;
  logic [2:0]        st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [6:0]        nbit_q, nbit_d;
  logic [DV_W-1:0]   dv_q, dv_d;
  logic              ph_q, ph_d, act_q, act_d, tail_q, tail_d;
  logic [1:0]        sel_q, sel_d;
  logic              init_q, init_d, last_q, last_d;
  logic [15:0]       sbass_q, sbass_d, svol_q, svol_d;
  logic              bval_q, bval_d, vval_q, vval_d;
  logic              xcs_q, xcs_d, xdcs_q, xdcs_d, sck_q, sck_d, si_q, si_d;
  logic              xreset_q, xreset_d, mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d, tdone_q, tdone_d;

  logic       do_wd, ld_en;
  logic [1:0] ld_sel;
  logic [6:0] nbit_nx;
  logic       go, bass_chg, vol_chg, trk_chg;

  assign nbit_nx  = nbit_q - 7'd1;
  assign go       = DREQ && play;
  assign bass_chg = !bval_q || (bass != sbass_q);
  assign vol_chg  = !vval_q || (volume != svol_q);
  assign trk_chg  = (track != track_q);

  // Reset release is synchronised; assertion acts immediately through the async path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
      track_q    <= '0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
      track_q    <= track;
    end
  end

  // Next-state logic: sequencer, shared bit engine, word-boundary decisions, restart.
  always_comb begin
    st_d = st_q;       cnt_d = cnt_q;     sh_d = sh_q;       nbit_d = nbit_q;
    dv_d = dv_q;       ph_d = ph_q;       act_d = act_q;     tail_d = tail_q;
    sel_d = sel_q;     init_d = init_q;   last_d = last_q;
    sbass_d = sbass_q; svol_d = svol_q;   bval_d = bval_q;   vval_d = vval_q;
    xcs_d = xcs_q;     xdcs_d = xdcs_q;   sck_d = sck_q;     si_d = si_q;
    xreset_d = xreset_q; mem_req_d = mem_req_q; mem_addr_d = mem_addr_q;
    busy_d = busy_q;   tdone_d = 1'b0;
    do_wd = 1'b0;      ld_en = 1'b0;      ld_sel = sel_q;

    case (st_q)
      S_BOOT: begin
        if (cnt_q == CNT_W'(BOOT_CYC - 1)) begin
          cnt_d = '0; st_d = S_HRST; xreset_d = 1'b0; busy_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_HRST: begin
        if (cnt_q == CNT_W'(HRESET_CYC - 1)) begin
          cnt_d = '0; st_d = S_SWAIT; xreset_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_SWAIT: begin
        if (cnt_q == CNT_W'(SRESET_CYC - 1)) begin
          cnt_d = '0; init_d = 1'b1; ld_en = 1'b1; ld_sel = F_MODE;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_SCI: begin
        if (tail_q) begin
          tail_d = 1'b0; xcs_d = 1'b1; st_d = S_GAP; cnt_d = '0;
        end else if (!act_q) begin
          // DREQ only gates the first bit; the frame then runs to completion.
          if (DREQ) begin
            act_d = 1'b1; xcs_d = 1'b0; si_d = sh_q[SH_W-1]; dv_d = '0; ph_d = 1'b0;
          end
        end else if (dv_q != DV_LAST) begin
          dv_d = dv_q + DV_W'(1);
        end else if (!ph_q) begin
          dv_d = '0; ph_d = 1'b1; sck_d = 1'b1;
        end else begin
          dv_d = '0; ph_d = 1'b0; sck_d = 1'b0; sh_d = sh_q << 1; nbit_d = nbit_nx;
          if (nbit_nx == 7'd0) begin
            act_d = 1'b0; tail_d = 1'b1; si_d = 1'b0;
          end else si_d = sh_q[SH_W-2];
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (init_q) begin
            if (sel_q != F_VOL) begin
              ld_en = 1'b1; ld_sel = sel_q + 2'd1;
            end else begin
              init_d = 1'b0; mem_req_d = 1'b1; st_d = S_FETCH;
            end
          end else do_wd = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_FETCH: begin
        if (mem_valid) begin
          sh_d = SH_W'(mem_data) << (SH_W - DATA_W);
          last_d = mem_last; mem_req_d = 1'b0; nbit_d = 7'(DATA_W);
          st_d = S_SDI; dv_d = '0; ph_d = 1'b0;
          if (go) begin
            act_d = 1'b1; xdcs_d = 1'b0; si_d = mem_data[DATA_W-1];
          end else act_d = 1'b0;
        end
      end
      S_SDI: begin
        if (!act_q) begin
          if (go) begin
            act_d = 1'b1; xdcs_d = 1'b0; si_d = sh_q[SH_W-1]; dv_d = '0; ph_d = 1'b0;
          end
        end else if (dv_q != DV_LAST) begin
          dv_d = dv_q + DV_W'(1);
        end else if (!ph_q) begin
          dv_d = '0; ph_d = 1'b1; sck_d = 1'b1;
        end else begin
          dv_d = '0; ph_d = 1'b0; sck_d = 1'b0; sh_d = sh_q << 1; nbit_d = nbit_nx;
          if (nbit_nx == 7'd0) begin
            act_d = 1'b0; xdcs_d = 1'b1; si_d = 1'b0; do_wd = 1'b1;
          end else if ((nbit_nx[2:0] == 3'd0) && !go) begin
            // Byte boundary with decoder full or paused: park between bytes.
            act_d = 1'b0; xdcs_d = 1'b1; si_d = 1'b0;
          end else si_d = sh_q[SH_W-2];
        end
      end
      default: ;
    endcase

    if (do_wd) begin
      if (bass_chg) begin
        ld_en = 1'b1; ld_sel = F_BASS;
      end else if (vol_chg) begin
        ld_en = 1'b1; ld_sel = F_VOL;
      end else if (last_q) begin
        tdone_d = 1'b1; busy_d = 1'b0; st_d = S_DONE;
      end else begin
        mem_addr_d = mem_addr_q + ADDR_W'(1); mem_req_d = 1'b1; st_d = S_FETCH;
      end
    end

    if (ld_en) begin
      sh_d = SH_W'(frame_word(ld_sel, bass, volume)) << (SH_W - 32);
      sel_d = ld_sel; nbit_d = 7'd32; act_d = 1'b0; tail_d = 1'b0;
      dv_d = '0; ph_d = 1'b0; st_d = S_SCI;
      if (ld_sel == F_BASS) begin sbass_d = bass;   bval_d = 1'b1; end
      if (ld_sel == F_VOL)  begin svol_d  = volume; vval_d = 1'b1; end
    end

    // Held reset after release and track change both restart from BOOT.
    if (!rst_sync_q || trk_chg) begin
      st_d = S_BOOT;   cnt_d = '0;      sh_d = '0;       nbit_d = '0;
      dv_d = '0;       ph_d = 1'b0;     act_d = 1'b0;    tail_d = 1'b0;
      sel_d = F_MODE;  init_d = 1'b0;   last_d = 1'b0;
      sbass_d = '0;    svol_d = '0;     bval_d = 1'b0;   vval_d = 1'b0;
      xcs_d = 1'b1;    xdcs_d = 1'b1;   sck_d = 1'b0;    si_d = 1'b0;
      xreset_d = 1'b1; mem_req_d = 1'b0; mem_addr_d = '0;
      busy_d = 1'b0;   tdone_d = 1'b0;
    end
  end

  // State and output registers; async reset forces idle outputs at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= S_BOOT;   cnt_q <= '0;      sh_q <= '0;       nbit_q <= '0;
      dv_q <= '0;       ph_q <= 1'b0;     act_q <= 1'b0;    tail_q <= 1'b0;
      sel_q <= F_MODE;  init_q <= 1'b0;   last_q <= 1'b0;
      sbass_q <= '0;    svol_q <= '0;     bval_q <= 1'b0;   vval_q <= 1'b0;
      xcs_q <= 1'b1;    xdcs_q <= 1'b1;   sck_q <= 1'b0;    si_q <= 1'b0;
      xreset_q <= 1'b1; mem_req_q <= 1'b0; mem_addr_q <= '0;
      busy_q <= 1'b0;   tdone_q <= 1'b0;
    end else begin
      st_q <= st_d;     cnt_q <= cnt_d;   sh_q <= sh_d;     nbit_q <= nbit_d;
      dv_q <= dv_d;     ph_q <= ph_d;     act_q <= act_d;   tail_q <= tail_d;
      sel_q <= sel_d;   init_q <= init_d; last_q <= last_d;
      sbass_q <= sbass_d; svol_q <= svol_d; bval_q <= bval_d; vval_q <= vval_d;
      xcs_q <= xcs_d;   xdcs_q <= xdcs_d; sck_q <= sck_d;   si_q <= si_d;
      xreset_q <= xreset_d; mem_req_q <= mem_req_d; mem_addr_q <= mem_addr_d;
      busy_q <= busy_d; tdone_q <= tdone_d;
    end
  end

  assign XCS        = xcs_q;
  assign XDCS       = xdcs_q;
  assign SCK        = sck_q;
  assign SI         = si_q;
  assign XRESET     = xreset_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign track_done = tdone_q;

endmodule
